uart_tx_arbiter: RTL

- Shares one UART transmitter (start/busy/data_in/txd serializer) among NUM_REQ byte-stream requesters.
- Round-robin arbitration at message granularity: a granted requester keeps the transmitter until it sends a byte flagged last.
- Sits between the console, debug and program-output sources and the single transmitter instance. Sequences that instance's start/busy handshake so no byte is dropped or double-launched.

---
 rtl/uart_tx_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular sharing of one UART transmitter among NUM_REQ byte sources.
// Optional TX_ARB_PREFIX_EN: each newly taken lock first transmits a header byte 8'h80|grant_id.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    output logic [ID_W-1:0]      grant_id,
    output logic                 locked
);

    typedef enum logic [1:0] {ARB, ISSUE, WAIT_ACC, WAIT_DONE} state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] grant_id_q, grant_id_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic            locked_q, locked_d;
    logic [7:0]      hold_data_q, hold_data_d;
    logic            hold_last_q, hold_last_d;
`ifdef TX_ARB_PREFIX_EN
    logic            hdr_pending_q, hdr_pending_d;
`endif

    logic [ID_W-1:0] win_id, idx, sel_id, next_ptr;
    logic            win_found, sel_valid;

    // First valid channel at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        idx       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = ID_W'((int'(rr_ptr_q) + i) % NUM_REQ);
            if (!win_found && req_valid[idx]) begin
                win_found = 1'b1;
                win_id    = idx;
            end
        end
    end

    assign sel_id    = locked_q ? grant_id_q : win_id;
    assign sel_valid = locked_q ? req_valid[grant_id_q] : win_found;
    assign next_ptr  = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        grant_id_d  = grant_id_q;
        rr_ptr_d    = rr_ptr_q;
        locked_d    = locked_q;
        hold_data_d = hold_data_q;
        hold_last_d = hold_last_q;
`ifdef TX_ARB_PREFIX_EN
        hdr_pending_d = hdr_pending_q;
`endif
        req_ready   = '0;
        tx_start    = 1'b0;
        case (state_q)
            ARB: begin
                if (sel_valid) begin
                    req_ready[sel_id] = 1'b1;
                    hold_data_d       = req_data[{sel_id, 3'b000} +: 8];
                    hold_last_d       = req_last[sel_id];
                    grant_id_d        = sel_id;
                    locked_d          = 1'b1;
`ifdef TX_ARB_PREFIX_EN
                    hdr_pending_d     = !locked_q;
`endif
                    state_d           = ISSUE;
                end
            end
            ISSUE: begin
                if (!tx_busy) begin
                    tx_start = 1'b1;
                    state_d  = WAIT_ACC;
                end
            end
            WAIT_ACC: begin
                if (tx_busy) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
`ifdef TX_ARB_PREFIX_EN
                    // Header just finished: the held requester byte goes out next.
                    if (hdr_pending_q) begin
                        hdr_pending_d = 1'b0;
                        state_d       = ISSUE;
                    end else
`endif
                    begin
                        state_d = ARB;
                        if (hold_last_q) begin
                            locked_d = 1'b0;
                            rr_ptr_d = next_ptr;
                        end
                    end
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ARB;
            grant_id_q  <= '0;
            rr_ptr_q    <= '0;
            locked_q    <= 1'b0;
            hold_data_q <= '0;
            hold_last_q <= 1'b0;
`ifdef TX_ARB_PREFIX_EN
            hdr_pending_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            grant_id_q  <= grant_id_d;
            rr_ptr_q    <= rr_ptr_d;
            locked_q    <= locked_d;
            hold_data_q <= hold_data_d;
            hold_last_q <= hold_last_d;
`ifdef TX_ARB_PREFIX_EN
            hdr_pending_q <= hdr_pending_d;
`endif
        end
    end

`ifdef TX_ARB_PREFIX_EN
    assign tx_data = hdr_pending_q ? (8'h80 | 8'(grant_id_q)) : hold_data_q;
`else
    assign tx_data = hold_data_q;
`endif
    assign grant_id = grant_id_q;
    assign locked   = locked_q;

endmodule
